// File: rtl/poly_pointwise_if.sv
// Write-in / stream-out bus of the pointwise unit. Signal names follow the
// unit's port list, so _i/_o are seen from the slave (the unit) side.
interface poly_pointwise_if #(
    parameter int DW = 32
);
    logic          pw_we_i;
    logic [1:0]    pw_addr_i;
    logic [DW-1:0] pw_wdata_i;
    logic          pw_rvalid_o;
    logic [DW-1:0] pw_rdata_o;
    logic          pw_busy_o;
    logic          pw_err_o;
    logic          pw_intr_o;

    modport slave (
        input  pw_we_i, pw_addr_i, pw_wdata_i,
        output pw_rvalid_o, pw_rdata_o, pw_busy_o, pw_err_o, pw_intr_o
    );

    modport master (
        output pw_we_i, pw_addr_i, pw_wdata_i,
        input  pw_rvalid_o, pw_rdata_o, pw_busy_o, pw_err_o, pw_intr_o
    );
endinterface

// File: rtl/poly_pointwise.sv
// Coefficient-wise mod-q add/sub/mul over two loaded polynomials (Kyber or Dilithium q).
// Optional scalar multiply (op 11, B load skipped) is built when POLY_PW_SCALAR_EN is defined.
module poly_pointwise #(
    parameter int N   = 256,
    parameter int DW  = 32,
    parameter int LAT = 4
) (
    input  logic           pw_clk_i,
    input  logic           pw_rst_i,
    poly_pointwise_if.slave bus
);
    localparam int AW = $clog2(N);
    localparam int CW = AW + 1;
    localparam int QW = 24;
    localparam int PW = 48;
    localparam int SD = LAT - 2;
    localparam logic [QW-1:0] Q_KY = 24'd3329;
    localparam logic [QW-1:0] Q_DI = 24'd8380417;
    localparam logic [95:0]   M_KY = (96'd1 << 48) / 96'd3329;
    localparam logic [95:0]   M_DI = (96'd1 << 48) / 96'd8380417;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_A = 2'd1,
        ST_LOAD_B = 2'd2,
        ST_RUN    = 2'd3
    } state_t;

    // Maps a signed input word onto [0,q); bit QW flags an out-of-range word.
    function automatic logic [QW:0] reduce_in(input logic [DW-1:0] x, input logic [QW-1:0] q);
        logic signed [DW-1:0] xs;
        logic signed [DW-1:0] qs;
        logic signed [DW-1:0] sum;
        logic [QW:0]          res;
        xs  = $signed(x);
        qs  = $signed({{(DW-QW){1'b0}}, q});
        sum = xs + qs;
        if (!x[DW-1] && (xs < qs)) begin
            res = {1'b0, x[QW-1:0]};
        end else if (x[DW-1] && !sum[DW-1] && (sum != {DW{1'b0}})) begin
            res = {1'b0, sum[QW-1:0]};
        end else begin
            res = {1'b1, {QW{1'b0}}};
        end
        return res;
    endfunction

    // Barrett with k=48: the quotient estimate is short by at most 2, hence two corrections.
    function automatic logic [QW-1:0] barrett(input logic [PW-1:0] p, input logic scheme);
        logic [95:0] qv;
        logic [95:0] prod;
        logic [95:0] qe;
        logic [95:0] r;
        qv   = scheme ? {72'd0, Q_DI} : {72'd0, Q_KY};
        prod = {48'd0, p} * (scheme ? M_DI : M_KY);
        qe   = prod >> 48;
        r    = {48'd0, p} - qe * qv;
        r    = (r >= qv) ? r - qv : r;
        r    = (r >= qv) ? r - qv : r;
        return r[QW-1:0];
    endfunction

    state_t          state_q;
    logic [CW-1:0]   wr_cnt_q;
    logic [CW-1:0]   rd_idx_q;
    logic [1:0]      op_q;
    logic            scheme_q;
`ifdef POLY_PW_SCALAR_EN
    logic [QW-1:0]   scalar_q;
`endif
    logic            busy_q;
    logic            err_q;
    logic [QW-1:0]   mem_a [N];
    logic [QW-1:0]   mem_b [N];
    logic            v1_q, last1_q, v2_q, last2_q;
    logic [QW-1:0]   a1_q, b1_q;
    logic [PW-1:0]   pre2_q;
    logic            st_v_q    [SD];
    logic            st_last_q [SD];
    logic [QW-1:0]   st_val_q  [SD];

    logic            cfg_wr_s, a_wr_s, b_wr_s, order_err_s;
    logic            range_bad_s, data_err_s, issue_s, last_load_s, skip_b_s, cfg_rsvd_s;
    logic [QW-1:0]   q_sel_s, wr_val_s, a_rd_s, b_rd_s;
    logic [AW-1:0]   rd_addr_s;
    logic [PW-1:0]   pre_s;

    // Write decode: which buffer takes the word, or whether it is an ordering error.
    always_comb begin
        cfg_wr_s    = 1'b0;
        a_wr_s      = 1'b0;
        b_wr_s      = 1'b0;
        order_err_s = 1'b0;
        if (bus.pw_we_i) begin
            case (bus.pw_addr_i)
                2'd0: begin
                    if (state_q == ST_IDLE || state_q == ST_LOAD_A) a_wr_s = 1'b1;
                    else order_err_s = 1'b1;
                end
                2'd1: cfg_wr_s = 1'b1;
                2'd2: begin
                    if (state_q == ST_LOAD_B) b_wr_s = 1'b1;
                    else order_err_s = 1'b1;
                end
                default: order_err_s = 1'b1;
            endcase
        end else begin
            order_err_s = 1'b0;
        end
    end

    // Datapath: input reduction, buffer read and stage-2 pre-reduction value.
    always_comb begin
        q_sel_s                   = scheme_q ? Q_DI : Q_KY;
        {range_bad_s, wr_val_s}   = reduce_in(bus.pw_wdata_i, q_sel_s);
        data_err_s                = range_bad_s && (a_wr_s || b_wr_s);
        issue_s                   = (state_q == ST_RUN) && !rd_idx_q[AW];
        rd_addr_s                 = rd_idx_q[AW-1:0];
        a_rd_s                    = mem_a[rd_addr_s];
        last_load_s               = (wr_cnt_q == CW'(N - 1));
`ifdef POLY_PW_SCALAR_EN
        b_rd_s                    = (op_q == 2'b11) ? scalar_q : mem_b[rd_addr_s];
        skip_b_s                  = (op_q == 2'b11);
        cfg_rsvd_s                = 1'b0;
`else
        b_rd_s                    = mem_b[rd_addr_s];
        skip_b_s                  = 1'b0;
        cfg_rsvd_s                = (bus.pw_wdata_i[1:0] == 2'b11);
`endif
        case (op_q)
            2'b00:   pre_s = {24'd0, a1_q} + {24'd0, b1_q};
            2'b01:   pre_s = {24'd0, a1_q} + {24'd0, q_sel_s} - {24'd0, b1_q};
            default: pre_s = {24'd0, a1_q} * {24'd0, b1_q};
        endcase
    end

    // Coefficient buffers; contents are always rewritten before they are read.
    always_ff @(posedge pw_clk_i) begin
        if (a_wr_s) mem_a[wr_cnt_q[AW-1:0]] <= wr_val_s;
        if (b_wr_s) mem_b[wr_cnt_q[AW-1:0]] <= wr_val_s;
    end

    // Control FSM, compute pipeline and registered outputs.
    always_ff @(posedge pw_clk_i or posedge pw_rst_i) begin
        if (pw_rst_i) begin
            state_q  <= ST_IDLE;
            wr_cnt_q <= {CW{1'b0}};
            rd_idx_q <= {CW{1'b0}};
            op_q     <= 2'b00;
            scheme_q <= 1'b0;
`ifdef POLY_PW_SCALAR_EN
            scalar_q <= {QW{1'b0}};
`endif
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            v1_q     <= 1'b0;
            last1_q  <= 1'b0;
            a1_q     <= {QW{1'b0}};
            b1_q     <= {QW{1'b0}};
            v2_q     <= 1'b0;
            last2_q  <= 1'b0;
            pre2_q   <= {PW{1'b0}};
            for (int k = 0; k < SD; k++) begin
                st_v_q[k]    <= 1'b0;
                st_last_q[k] <= 1'b0;
                st_val_q[k]  <= {QW{1'b0}};
            end
        end else begin
            v1_q         <= issue_s;
            last1_q      <= issue_s && (rd_addr_s == {AW{1'b1}});
            a1_q         <= a_rd_s;
            b1_q         <= b_rd_s;
            v2_q         <= v1_q;
            last2_q      <= last1_q;
            pre2_q       <= pre_s;
            st_v_q[0]    <= v2_q;
            st_last_q[0] <= v2_q && last2_q;
            st_val_q[0]  <= v2_q ? barrett(pre2_q, scheme_q) : {QW{1'b0}};
            for (int k = 1; k < SD; k++) begin
                st_v_q[k]    <= st_v_q[k-1];
                st_last_q[k] <= st_last_q[k-1];
                st_val_q[k]  <= st_val_q[k-1];
            end
            if (issue_s) rd_idx_q <= rd_idx_q + CW'(1);

            if (cfg_wr_s) begin
                op_q     <= bus.pw_wdata_i[1:0];
                scheme_q <= bus.pw_wdata_i[2];
`ifdef POLY_PW_SCALAR_EN
                scalar_q <= bus.pw_wdata_i[QW+7:8];
`endif
                err_q    <= cfg_rsvd_s;
                state_q  <= ST_IDLE;
                wr_cnt_q <= {CW{1'b0}};
                rd_idx_q <= {CW{1'b0}};
                busy_q   <= 1'b0;
                v1_q     <= 1'b0;
                last1_q  <= 1'b0;
                v2_q     <= 1'b0;
                last2_q  <= 1'b0;
                for (int k = 0; k < SD; k++) begin
                    st_v_q[k]    <= 1'b0;
                    st_last_q[k] <= 1'b0;
                    st_val_q[k]  <= {QW{1'b0}};
                end
            end else begin
                if (order_err_s || data_err_s) err_q <= 1'b1;
                case (state_q)
                    ST_IDLE: begin
                        if (a_wr_s) begin
                            state_q  <= ST_LOAD_A;
                            wr_cnt_q <= CW'(1);
                            busy_q   <= 1'b1;
                        end
                    end
                    ST_LOAD_A: begin
                        if (a_wr_s && last_load_s) begin
                            wr_cnt_q <= {CW{1'b0}};
                            rd_idx_q <= {CW{1'b0}};
                            state_q  <= skip_b_s ? ST_RUN : ST_LOAD_B;
                        end else if (a_wr_s) begin
                            wr_cnt_q <= wr_cnt_q + CW'(1);
                        end
                    end
                    ST_LOAD_B: begin
                        if (b_wr_s && last_load_s) begin
                            wr_cnt_q <= {CW{1'b0}};
                            rd_idx_q <= {CW{1'b0}};
                            state_q  <= ST_RUN;
                        end else if (b_wr_s) begin
                            wr_cnt_q <= wr_cnt_q + CW'(1);
                        end
                    end
                    ST_RUN: begin
                        if (st_last_q[SD-1]) begin
                            state_q  <= ST_IDLE;
                            busy_q   <= 1'b0;
                            rd_idx_q <= {CW{1'b0}};
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.pw_rvalid_o = st_v_q[SD-1];
    assign bus.pw_rdata_o  = {{(DW-QW){1'b0}}, st_val_q[SD-1]};
    assign bus.pw_intr_o   = st_last_q[SD-1];
    assign bus.pw_busy_o   = busy_q;
    assign bus.pw_err_o    = err_q;
endmodule

// File: tb/tb_poly_pointwise.sv
// Directed bench for poly_pointwise: loads, streams and checks each run against
// expected tables filled in from hand-derived formulas.
module tb_poly_pointwise;
    localparam int N   = 256;
    localparam int DW  = 32;
    localparam int LAT = 4;
    localparam int QK  = 3329;
    localparam int QD  = 8380417;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   va [N];
    int   vb [N];
    int   ex [N];

    poly_pointwise_if #(.DW(DW)) bus ();
    poly_pointwise #(.N(N), .DW(DW), .LAT(LAT)) dut (
        .pw_clk_i (clk),
        .pw_rst_i (rst),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.pw_we_i    = 1'b1;
        bus.pw_addr_i  = a;
        bus.pw_wdata_i = d;
        @(negedge clk);
        bus.pw_we_i    = 1'b0;
        bus.pw_addr_i  = 2'd0;
        bus.pw_wdata_i = 32'd0;
    endtask

    task automatic load(input bit with_b);
        for (int i = 0; i < N; i++) wr(2'd0, va[i]);
        if (with_b) begin
            for (int i = 0; i < N; i++) wr(2'd2, vb[i]);
        end
    endtask

    // c0 is the cycle index (relative to the last load write) at entry.
    task automatic collect(input string tag, input int c0);
        int c;
        c = c0;
        while (bus.pw_rvalid_o !== 1'b1 && c < LAT + 40) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_latency"}, 64'(c), 64'(LAT + 1));
        for (int i = 0; i < N; i++) begin
            check({tag, "_valid"}, 64'(bus.pw_rvalid_o), 64'd1);
            check({tag, "_data"}, 64'(bus.pw_rdata_o), 64'(ex[i]));
            check({tag, "_intr"}, 64'(bus.pw_intr_o), 64'(i == N - 1));
            @(negedge clk);
        end
        check({tag, "_end_valid"}, 64'(bus.pw_rvalid_o), 64'd0);
        check({tag, "_end_busy"}, 64'(bus.pw_busy_o), 64'd0);
    endtask

    initial begin
        int c;
        bus.pw_we_i    = 1'b0;
        bus.pw_addr_i  = 2'd0;
        bus.pw_wdata_i = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_rvalid", 64'(bus.pw_rvalid_o), 64'd0);
        check("rst_rdata", 64'(bus.pw_rdata_o), 64'd0);
        check("rst_busy", 64'(bus.pw_busy_o), 64'd0);
        check("rst_err", 64'(bus.pw_err_o), 64'd0);
        check("rst_intr", 64'(bus.pw_intr_o), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Dilithium mul, A[i]=B[i]=i
        wr(2'd1, 32'd6);
        for (int i = 0; i < N; i++) begin va[i] = i; vb[i] = i; ex[i] = i * i; end
        for (int i = 0; i < N; i++) wr(2'd0, va[i]);
        check("load_busy", 64'(bus.pw_busy_o), 64'd1);
        for (int i = 0; i < N; i++) wr(2'd2, vb[i]);
        collect("dil_mul", 1);
        check("dil_mul_err", 64'(bus.pw_err_o), 64'd0);

        // Kyber add with B = q-1
        wr(2'd1, 32'd0);
        for (int i = 0; i < N; i++) begin va[i] = i; vb[i] = 3328; ex[i] = (i == 0) ? 3328 : i - 1; end
        load(1'b1);
        collect("ky_add", 1);
        check("ky_add_err", 64'(bus.pw_err_o), 64'd0);

        // Kyber sub, A=-1, B=1
        wr(2'd1, 32'd1);
        for (int i = 0; i < N; i++) begin va[i] = -1; vb[i] = 1; ex[i] = 3327; end
        load(1'b1);
        collect("ky_sub", 1);
        check("ky_sub_err", 64'(bus.pw_err_o), 64'd0);

        // Dilithium mul at the input range boundaries; config retained between runs
        wr(2'd1, 32'd6);
        for (int i = 0; i < N; i++) begin va[i] = QD - 1; vb[i] = QD - 1; ex[i] = 1; end
        load(1'b1);
        collect("dil_m1", 1);
        check("dil_m1_err", 64'(bus.pw_err_o), 64'd0);
        for (int i = 0; i < N; i++) begin va[i] = -(QD - 1); vb[i] = -(QD - 1); ex[i] = 1; end
        load(1'b1);
        collect("dil_neg", 1);
        check("dil_neg_err", 64'(bus.pw_err_o), 64'd0);
        for (int i = 0; i < N; i++) begin va[i] = QD; vb[i] = 1; ex[i] = 0; end
        load(1'b1);
        collect("dil_ovr", 1);
        check("dil_ovr_err", 64'(bus.pw_err_o), 64'd1);

        // Abort after 100 A writes, then a fresh full load
        for (int i = 0; i < 100; i++) wr(2'd0, 32'd7);
        check("abort_busy_before", 64'(bus.pw_busy_o), 64'd1);
        wr(2'd1, 32'd6);
        check("abort_busy", 64'(bus.pw_busy_o), 64'd0);
        check("abort_err", 64'(bus.pw_err_o), 64'd0);
        check("abort_rvalid", 64'(bus.pw_rvalid_o), 64'd0);
        for (int i = 0; i < N; i++) begin va[i] = i; vb[i] = 2; ex[i] = 2 * i; end
        load(1'b1);
        collect("fresh", 1);

        // Data write while running: flagged, stream unaffected
        wr(2'd1, 32'd2);
        for (int i = 0; i < N; i++) begin va[i] = i; vb[i] = i; ex[i] = (i * i) % QK; end
        load(1'b1);
        wr(2'd0, 32'd99);
        collect("run_wr", 2);
        check("run_wr_err", 64'(bus.pw_err_o), 64'd1);

        // B write in IDLE: flagged, unit stays idle and the next load works
        wr(2'd1, 32'd2);
        check("idle_b_err_clear", 64'(bus.pw_err_o), 64'd0);
        wr(2'd2, 32'd5);
        check("idle_b_err", 64'(bus.pw_err_o), 64'd1);
        check("idle_b_busy", 64'(bus.pw_busy_o), 64'd0);
        load(1'b1);
        collect("after_idle_b", 1);
        check("after_idle_b_err", 64'(bus.pw_err_o), 64'd1);

`ifdef POLY_PW_SCALAR_EN
        // Scalar multiply by c=2, Kyber, A only
        wr(2'd1, 32'h0000_0203);
        check("scalar_cfg_err", 64'(bus.pw_err_o), 64'd0);
        for (int i = 0; i < N; i++) begin va[i] = i; ex[i] = (2 * i) % QK; end
        load(1'b0);
        collect("scalar", 1);
`else
        // Reserved op 11: flagged at config write, runs as mul
        wr(2'd1, 32'd3);
        check("rsvd_err", 64'(bus.pw_err_o), 64'd1);
        for (int i = 0; i < N; i++) begin va[i] = i; vb[i] = i; ex[i] = (i * i) % QK; end
        load(1'b1);
        collect("rsvd_mul", 1);
`endif

        // Reset at the 10th result, then a clean Dilithium sub run
        wr(2'd1, 32'd6);
        for (int i = 0; i < N; i++) begin va[i] = i; vb[i] = i; ex[i] = i * i; end
        for (int i = 0; i < 50; i++) wr(2'd0, va[i]);
        wr(2'd3, 32'd0);
        check("addr3_err", 64'(bus.pw_err_o), 64'd1);
        for (int i = 50; i < N; i++) wr(2'd0, va[i]);
        for (int i = 0; i < N; i++) wr(2'd2, vb[i]);
        c = 1;
        while (bus.pw_rvalid_o !== 1'b1 && c < LAT + 40) begin
            @(negedge clk);
            c++;
        end
        repeat (9) @(negedge clk);
        check("tenth_valid", 64'(bus.pw_rvalid_o), 64'd1);
        check("tenth_data", 64'(bus.pw_rdata_o), 64'd81);
        rst = 1'b1;
        #1;
        check("arst_rvalid", 64'(bus.pw_rvalid_o), 64'd0);
        check("arst_intr", 64'(bus.pw_intr_o), 64'd0);
        check("arst_busy", 64'(bus.pw_busy_o), 64'd0);
        check("arst_err", 64'(bus.pw_err_o), 64'd0);
        check("arst_rdata", 64'(bus.pw_rdata_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wr(2'd1, 32'd5);
        for (int i = 0; i < N; i++) begin va[i] = i; vb[i] = 2 * i; ex[i] = (i == 0) ? 0 : QD - i; end
        load(1'b1);
        collect("post_rst_sub", 1);
        check("post_rst_err", 64'(bus.pw_err_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/poly_pointwise.md
Name: poly_pointwise

Overview:
- Streaming coefficient-wise arithmetic unit for the lattice accelerator. It sits beside the ntt core on the same write-in / stream-out bus style.
- Loads polynomial A, then polynomial B, N coefficients each. It computes mod-q add, sub, or multiply per coefficient and streams N canonical results.
- Supports both Kyber (q=3329) and Dilithium (q=8380417), selected at run time through a config word.

Parameters:
- N, 256, coefficients per polynomial (power of 2, 16..1024)
- DW, 32, bus/coefficient width (signed two's complement)
- LAT, 4, fixed compute latency in cycles for all ops (≥3)

Ports:
- pw_clk_i  in  1  clock, all logic on rising edge
- pw_rst_i  in  1  asynchronous, active-high reset
- pw_we_i  in  1  write strobe, one word accepted per cycle
- pw_addr_i  in  2  0 = A data, 1 = config, 2 = B data, 3 = reserved
- pw_wdata_i  in  DW  coefficient or config word
- pw_rvalid_o  out  1  result valid
- pw_rdata_o  out  DW  result coefficient in [0,q), zero-extended
- pw_busy_o  out  1  high from first A write until last result
- pw_err_o  out  1  sticky error flag
- pw_intr_o  out  1  one-cycle done pulse

Behaviour:
- Reset: all outputs 0, state IDLE, config 0, counters 0, err 0. Buffer contents are don't-care.
- Config word:
  - [1:0] op: 00 add, 01 sub, 10 mul, 11 scalar-mul (macro only).
  - [2] scheme: 0 Kyber q=3329, 1 Dilithium q=8380417.
  - [31:8] scalar c (op 11).
  - Config is retained across runs.
- Config write (addr 1), any state:
  - latches config, clears err, clears counters, forces IDLE;
  - aborts any load or stream in progress; rvalid drops the next cycle.
- States and transitions:
  - IDLE → LOAD_A on the first addr-0 write.
  - LOAD_A → LOAD_B after N addr-0 writes.
  - LOAD_B → RUN after N addr-2 writes.
  - RUN → IDLE after N results.
- Write-order errors (write ignored, err set):
  - addr-2 write in IDLE or LOAD_A;
  - addr-0 write in LOAD_B;
  - any data write in RUN;
  - addr 3 at any time.
  - Writes need not be consecutive.
- Input reduction: x in [0,q) is used as-is; x in (-q,0) maps to x+q; any other x maps to 0 and sets err.
- RUN timing:
  - Let t be the cycle the last B write is accepted.
  - Index i is read at t+1+i; its result is valid at t+1+i+LAT.
  - rvalid is high for exactly N consecutive cycles, results in index order, no gaps.
  - intr pulses in the cycle of the last rvalid. busy falls the next cycle.
- Arithmetic, all results canonical [0,q):
  - add: (a+b) mod q.
  - sub: (a−b) mod q.
  - mul: (a·b) mod q, full 46-bit product reduced exactly; Barrett permitted.
  - Add and sub are delay-padded to LAT.
- rdata is 0 whenever rvalid is low.
- Back-to-back runs: a new addr-0 write is accepted in IDLE, including the cycle after the last rvalid.
- Reserved op 11 without the macro: err set at config write. Subsequent loads run as mul.
- Async reset mid-run: outputs clear immediately, pipeline contents discarded.

Optional Feature:
- Macro POLY_PW_SCALAR_EN.
- Defined: op 11 computes (a·c') mod q, where c' = config[31:8] mod q. B load is skipped: LOAD_A → RUN after N A writes, with t = the last A write. Timing otherwise identical.
- Undefined: op 11 is reserved (see Behaviour) and no scalar logic is built.

Test Plan:
- Dilithium mul, A[i]=B[i]=i, i=0..255, LAT=4 → out[i]=i², out[255]=65025. First rvalid exactly 5 cycles after the last B write; 256 contiguous valids; intr on the last.
- Kyber add, A[i]=i, B[i]=3328 → out[0]=3328, out[1]=0, out[255]=254. Kyber sub, A[i]=−1, B[i]=1 → all 3327. err stays 0.
- Dilithium mul, A=B=8380416 (≡−1) → all outputs 1. A=B=−8380416 → all 1. A=8380417 → output 0 and err=1.
- Config write after 100 A writes → state IDLE, err cleared. A fresh 256+256 load produces a correct full result with no stale data.
- Addr-0 write during RUN → err=1, streamed results unchanged. Addr-2 write in IDLE → err=1, state stays IDLE.
- Reset asserted at the 10th rvalid → rvalid, intr, busy and err all 0 within the same cycle; a subsequent full run is correct. With POLY_PW_SCALAR_EN: op 11, c=2, Kyber, A[i]=i → out[i]=2i mod 3329.
